gpr_write_arbiter: RTL and testbench
====================================

// Module: gpr_write_arbiter
// PURPOSE
//   Shares the single register-file write port between NREQ writeback sources (e.g. ALU, load, mul/div).
//   Per-requester valid/ready handshake; round-robin arbitration grants at most one write per cycle.
//   Registered output stage drives reg_write/num_write/data_write of the register file directly.
//   The register file commits on the edge after the output stage loads: two edges from grant to architectural update.
// PARAMETERS
//   NREQ   3   number of writeback requesters (2..8)
//   PTR_W  3   width of round-robin pointer / grant_id; must satisfy 2**PTR_W >= NREQ
// PORTS
//   clock       in   1         rising-edge clock
//   reset       in   1         synchronous, active-high reset
//   req_valid   in   NREQ      requester i has a write pending
//   req_num     in   5*NREQ    dest register of requester i, bits [5*i+4:5*i]
//   req_data    in   32*NREQ   write data of requester i, bits [32*i+31:32*i]
//   req_ready   out  NREQ      one-hot grant; transfer when req_valid[i] & req_ready[i]
//   reg_write   out  1         write enable to register file (registered)
//   num_write   out  5         destination register (registered)
//   data_write  out  32        write data (registered)
//   grant_id    out  PTR_W     index of requester whose write is in the output stage
//   busy        out  1         reg_write asserted this cycle (alias, for pipeline forwarding)
// BEHAVIOUR
//   Reset (sync, highest priority): rr_ptr<=0, reg_write<=0, num_write<=0, data_write<=0, grant_id<=0.
//   Reset clears any in-flight output-stage write. req_ready is 0 in every cycle reset is high.
//   Arbitration (combinational, same cycle): search i = rr_ptr, rr_ptr+1, ... mod NREQ.
//   First i with req_valid[i]=1 wins, and req_ready = one-hot(i). No valid requester -> req_ready = 0.
//   req_ready never asserts for a requester whose req_valid is 0; at most one bit set.
//   Edge with a winner w:
//     reg_write<=(req_num[w]!=0), num_write<=req_num[w], data_write<=req_data[w], grant_id<=w.
//     rr_ptr<=(w==NREQ-1)?0:w+1.
//   Edge with no winner: reg_write<=0; num_write/data_write/grant_id/rr_ptr hold.
//   Register 0: request is accepted (handshake completes) but reg_write stays 0 -> no write issued.
//   Latency: grant in cycle N -> reg_write high in cycle N+1 -> register file updated at end of N+1.
//   Throughput: one write per cycle sustained; output stage never stalls (register file always accepts).
//   Fairness: a continuously valid requester is granted within NREQ cycles.
//   Requesters must hold req_valid/num/data stable until granted; the arbiter does not buffer un-granted requests.
//   Same destination from two requesters in one cycle: only the winner is written.
//     The loser is written on a later cycle, so the later grant's value is final.
//   Requester dropping valid before grant: request is lost silently (protocol violation, not detected).
//   rr_ptr only ever holds values 0..NREQ-1.
//   busy == reg_write; forwarding logic compares num_write with read addresses while busy=1.
// TESTING
//   1 Reset: assert reset 2 cycles with all req_valid=1 -> req_ready=0, reg_write=0, num_write=0, grant_id=0.
//   2 Single req: req_valid=3'b010, num=5, data=32'hDEADBEEF -> req_ready=3'b010 same cycle;
//     next cycle reg_write=1, num_write=5, data_write=DEADBEEF, grant_id=1; register r5 reads DEADBEEF one cycle later.
//   3 Round robin: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; reg_write=1 every cycle after first.
//   4 Register zero: req0 num=0, data=32'h1234 -> req_ready[0]=1, next cycle reg_write=0; r0 still reads 0.
//   5 Collision: req0 and req2 both num=7, data 11 and 22, rr_ptr=2 -> req2 first, then req0; r7 ends as 11.
//   6 Reset mid-op: reset high in the cycle after a grant -> reg_write=0 next cycle, write not committed, rr_ptr=0.

Source files
------------

// File: rtl/gpr_write_arbiter.sv
`default_nettype none
// ============================================================================
// gpr_write_arbiter: round-robin arbiter that shares the one register-file
// write port among NREQ writeback sources, with a registered output stage.
// Revision: 1.0
// ============================================================================
module gpr_write_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [5*NREQ-1:0]   req_num,
  input  logic [32*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                reg_write,
  output logic [4:0]          num_write,
  output logic [31:0]         data_write,
  output logic [PTR_W-1:0]    grant_id,
  output logic                busy
);

  localparam int             NSLOT  = 2**PTR_W;
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ-1);

  // Requester fields unpacked into power-of-two arrays so the PTR_W-bit
  // winner index selects without width adaptation; unused slots are idle.
  logic [NSLOT-1:0] valid_pad;
  logic [4:0]       num_arr  [NSLOT];
  logic [31:0]      data_arr [NSLOT];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_unpack
    if (gi < NREQ) begin : g_real
      assign valid_pad[gi] = req_valid[gi];
      assign num_arr[gi]   = req_num[5*gi +: 5];
      assign data_arr[gi]  = req_data[32*gi +: 32];
    end else begin : g_pad
      assign valid_pad[gi] = 1'b0;
      assign num_arr[gi]   = 5'd0;
      assign data_arr[gi]  = 32'd0;
    end
  end

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       num_write_q, num_write_d;
  logic [31:0]      data_write_q, data_write_d;
  logic [PTR_W-1:0] grant_id_q, grant_id_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   cand;

  // Circular search starting at the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && valid_pad[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    rr_ptr_d     = rr_ptr_q;
    reg_write_d  = 1'b0;
    num_write_d  = num_write_q;
    data_write_d = data_write_q;
    grant_id_d   = grant_id_q;
    if (reset) begin
      rr_ptr_d     = '0;
      num_write_d  = 5'd0;
      data_write_d = 32'd0;
      grant_id_d   = '0;
    end else if (win_found) begin
      req_ready    = NREQ'(1) << win_idx;
      // Writes to r0 complete the handshake but never enable the port.
      reg_write_d  = (num_arr[win_idx] != 5'd0);
      num_write_d  = num_arr[win_idx];
      data_write_d = data_arr[win_idx];
      grant_id_d   = win_idx;
      rr_ptr_d     = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    rr_ptr_q     <= rr_ptr_d;
    reg_write_q  <= reg_write_d;
    num_write_q  <= num_write_d;
    data_write_q <= data_write_d;
    grant_id_q   <= grant_id_d;
  end

  assign reg_write  = reg_write_q;
  assign num_write  = num_write_q;
  assign data_write = data_write_q;
  assign grant_id   = grant_id_q;
  assign busy       = reg_write_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gpr_write_arbiter: scoreboard bench with a reference arbiter and a
// register-file model fed by the DUT write port.
// Revision: 1.0
// ============================================================================
module tb_gpr_write_arbiter;

  localparam int NREQ  = 3;
  localparam int PTR_W = 3;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_num;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              reg_write;
  logic [4:0]        num_write;
  logic [31:0]       data_write;
  logic [PTR_W-1:0]  grant_id;
  logic              busy;

  gpr_write_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_num    (req_num),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .reg_write  (reg_write),
    .num_write  (num_write),
    .data_write (data_write),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        rw;
    logic [4:0]  num;
    logic [31:0] data;
    logic [2:0]  gid;
  } out_t;

  out_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   m_ptr  = 0;

  // Register file: commits on the edge following the output stage, not in reset.
  logic [31:0] rf [32];
  always @(posedge clock) begin
    if (!reset && reg_write && num_write != 5'd0) rf[num_write] <= data_write;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1: drives one cycle, checks, advances to next posedge+1.
  task automatic cyc(input logic rst, input logic [2:0] v,
                     input logic [4:0] n0, input logic [4:0] n1, input logic [4:0] n2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    logic [4:0]  nums [3];
    logic [31:0] dats [3];
    logic [2:0]  exp_rdy;
    out_t        e, o;
    int          w;
    nums[0] = n0; nums[1] = n1; nums[2] = n2;
    dats[0] = d0; dats[1] = d1; dats[2] = d2;
    reset     = rst;
    req_valid = v;
    req_num   = {n2, n1, n0};
    req_data  = {d2, d1, d0};
    #3;
    if (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      check("reg_write",  {63'd0, reg_write}, {63'd0, o.rw});
      check("busy",       {63'd0, busy},      {63'd0, o.rw});
      check("num_write",  {59'd0, num_write}, {59'd0, o.num});
      check("data_write", {32'd0, data_write}, {32'd0, o.data});
      check("grant_id",   {61'd0, grant_id},  {61'd0, o.gid});
    end
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (w < 0 && v[idx]) w = idx;
    end
    exp_rdy = 3'b000;
    if (rst) begin
      m_ptr = 0;
      e = '0;
    end else if (w >= 0) begin
      exp_rdy = 3'b001 << w;
      e.rw   = (nums[w] != 5'd0);
      e.num  = nums[w];
      e.data = dats[w];
      e.gid  = 3'(w);
      m_ptr  = (w == NREQ-1) ? 0 : w + 1;
    end else begin
      e = o;
      e.rw = 1'b0;
      if (exp_q.size() > 0) e = exp_q[$];
      e.rw = 1'b0;
    end
    check("req_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset = 1'b1; req_valid = '0; req_num = '0; req_data = '0;
    @(posedge clock); #1;

    // Reset with every requester valid.
    cyc(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    cyc(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);

    // Single requester, then let the write commit.
    cyc(1'b0, 3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    idle();
    check("rf_r5", {32'd0, rf[5]}, {32'd0, 32'hDEADBEEF});

    // Round robin from reset.
    cyc(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 32'hA0 + 32'(i), 32'hB0 + 32'(i), 32'hC0 + 32'(i));
    idle();

    // Register zero write is accepted but not issued.
    cyc(1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0);
    idle();
    check("rf_r0", {32'd0, rf[0]}, 64'd0);

    // Move pointer to 2, then collide on r7.
    cyc(1'b0, 3'b010, 5'd0, 5'd3, 5'd0, 32'd0, 32'h33, 32'd0);
    cyc(1'b0, 3'b101, 5'd7, 5'd0, 5'd7, 32'd11, 32'd0, 32'd22);
    cyc(1'b0, 3'b001, 5'd7, 5'd0, 5'd0, 32'd11, 32'd0, 32'd0);
    idle();
    check("rf_r7", {32'd0, rf[7]}, {32'd0, 32'd11});

    // Reset in the cycle after a grant drops the in-flight write.
    cyc(1'b0, 3'b010, 5'd0, 5'd9, 5'd0, 32'd0, 32'hAAAA, 32'd0);
    cyc(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    idle();
    check("rf_r9", {32'd0, rf[9]}, 64'd0);
    cyc(1'b0, 3'b111, 5'd4, 5'd6, 5'd8, 32'h44, 32'h66, 32'h88);
    idle();
    idle();
    check("rf_r4", {32'd0, rf[4]}, {32'd0, 32'h44});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
